id_regfile_hazard: RTL and testbench
====================================

# id_regfile_hazard

Decode-stage block sitting directly upstream of the ID/EX pipeline register. It holds the 8×16 architectural register file, which is written back from WB and read combinationally in ID. It also detects load-use hazards against the instruction currently held in ID/EX. It drives the pipeline hold (PC and IF/ID) and the bubble input that zeroes RegWrite/DMemEn/DMemWrite entering ID/EX, and keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- REG_W, 16: data width.
- NREG, 8: number of registers.
- SEL_W, 3: register select width (log2 NREG).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- rd_sel1  in  3  source register 1 select (Rs).
- rd_sel2  in  3  source register 2 select (Rt).
- rd_use1  in  1  instruction in ID actually reads source 1.
- rd_use2  in  1  instruction in ID actually reads source 2.
- wr_en  in  1  WB-stage register write enable.
- wr_sel  in  3  WB-stage destination register.
- wr_data  in  16  WB-stage write data.
- ex_regwrite  in  1  RegWrite of instruction in ID/EX.
- ex_memtoreg  in  1  MemtoReg of instruction in ID/EX (load).
- ex_dst  in  3  destination register of instruction in ID/EX.
- ReadData1  out  16  source 1 data.
- ReadData2  out  16  source 2 data.
- stall  out  1  hold PC and IF/ID this cycle.
- bubble  out  1  drive ID/EX En low this cycle (equal to stall).
- stall_count  out  16  saturating count of stall cycles since reset.

## Operation
- Storage: NREG×REG_W flops. R0 is an ordinary register, not hard-wired to zero.
- Write: on a rising edge with wr_en=1 and rst=0, reg[wr_sel] <= wr_data.
- Read: ReadDataN = reg[rd_selN], combinational. The bypass rule is under Configuration.
- Load-use hazard:
  - ld_haz = ex_regwrite & ex_memtoreg & ((rd_use1 & ex_dst==rd_sel1) | (rd_use2 & ex_dst==rd_sel2)).
  - A source with rd_useN=0 never causes a stall.
- stall = bubble = ld_haz | wb_haz. wb_haz is defined under Configuration and is 0 when bypass is compiled in.
- Counter:
  - stall_count increments by 1 on each rising edge where stall=1.
  - It holds at 16'hFFFF (no wrap).
- Reset (synchronous):
  - All registers clear to 16'h0000; stall_count clears to 0.
  - stall and bubble are combinational and take their value from the inputs only.
  - If rst and wr_en are high in the same cycle, reset wins and the write is dropped.
- Reset mid-stall: the counter clears; stall continues to follow the inputs in the next cycle.

## Timing
- Read latency: 0 cycles, combinational from rd_sel/reg state.
- Write visible to reads:
  - Same cycle when bypass is compiled in.
  - Otherwise the cycle after the write edge.
- stall/bubble: combinational, valid in the same cycle as the inputs. No registered delay.
- One load-use hazard produces exactly one stall cycle. In the next cycle the load has moved to EX/MEM, ID/EX holds the bubble (ex_regwrite=0), and stall drops.
- stall_count reflects a stall cycle one edge after that cycle.

## Configuration
- Macro: ID_RF_BYPASS_EN.
- Defined:
  - Write-to-read bypass: if wr_en & wr_sel==rd_selN, ReadDataN = wr_data in the same cycle.
  - wb_haz = 0.
- Undefined:
  - No bypass; ReadDataN always returns the stored value.
  - wb_haz = wr_en & ((rd_use1 & wr_sel==rd_sel1) | (rd_use2 & wr_sel==rd_sel2)).
  - The ID instruction is stalled one cycle so that it rereads the value once it is committed.

## Structure
- Shared package id_pkg: REG_W, NREG, SEL_W constants; typedef reg_sel_t (3-bit) and reg_data_t (16-bit).
- Sub-module rf_core: 8×16 storage, write port, two read ports, and bypass muxing under ID_RF_BYPASS_EN.
- Top-level logic: hazard compare logic and the stall counter.

## Test plan
- Reset, then read all 8 registers -> every ReadData = 16'h0000; stall_count = 0.
- Write R3=16'hBEEF; next cycle read rd_sel1=3 -> ReadData1=16'hBEEF. With bypass: the same cycle as the write also returns 16'hBEEF. Without bypass: stall=1 that cycle, and the value reads correctly the next cycle.
- ex_regwrite=1, ex_memtoreg=1, ex_dst=5, rd_sel2=5, rd_use2=1 -> stall=bubble=1 for one cycle; stall_count goes 0 -> 1. With rd_use2=0 instead -> stall=0.
- ex_regwrite=1, ex_memtoreg=0 (ALU op), ex_dst=5, rd_sel1=5 -> stall=0; ID/EX forwarding covers this case.
- Hold the load-use condition for 70000 cycles -> stall_count saturates at 16'hFFFF and does not wrap.
- wr_en=1, wr_sel=2, wr_data=16'h1234 together with rst=1 -> R2 reads 16'h0000 after the edge.

Source files
------------

// File: rtl/id_regfile_hazard_pkg.sv
// id_pkg: shared constants and types for the decode-stage register file
// and hazard unit.
//   REG_W  data width
//   NREG   number of architectural registers
//   SEL_W  register select width
//   reg_sel_t / reg_data_t  select and data types
package id_pkg;
    localparam int REG_W = 16;
    localparam int NREG  = 8;
    localparam int SEL_W = 3;

    typedef logic [SEL_W-1:0] reg_sel_t;
    typedef logic [REG_W-1:0] reg_data_t;
endpackage

// File: rtl/id_regfile_hazard_rf_core.sv
// rf_core: NREG x REG_W register file with one write port and two
// combinational read ports. R0 is an ordinary register.
// Optional feature macro: ID_RF_BYPASS_EN (write-to-read bypass).
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears all regs)
//   rd_sel1/2           read selects
//   wr_en/wr_sel/wr_data write port (dropped while rst is high)
//   ReadData1/2         combinational read data
module rf_core
    import id_pkg::*;
#(
    parameter int REG_W = id_pkg::REG_W,
    parameter int NREG  = id_pkg::NREG,
    parameter int SEL_W = id_pkg::SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] rd_sel1,
    input  logic [SEL_W-1:0] rd_sel2,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [REG_W-1:0] wr_data,
    output logic [REG_W-1:0] ReadData1,
    output logic [REG_W-1:0] ReadData2
);

    logic [REG_W-1:0] regs_q [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wr_sel] <= wr_data;
        end
    end

`ifdef ID_RF_BYPASS_EN
    // A write in flight this cycle is returned directly to a matching reader.
    always_comb begin
        ReadData1 = regs_q[rd_sel1];
        ReadData2 = regs_q[rd_sel2];
        if (wr_en && (wr_sel == rd_sel1)) ReadData1 = wr_data;
        if (wr_en && (wr_sel == rd_sel2)) ReadData2 = wr_data;
    end
`else
    always_comb begin
        ReadData1 = regs_q[rd_sel1];
        ReadData2 = regs_q[rd_sel2];
    end
`endif

endmodule

// File: rtl/id_regfile_hazard.sv
// id_regfile_hazard: decode-stage register file plus load-use hazard
// detection, pipeline stall/bubble generation and a saturating stall counter.
// Optional feature macro: ID_RF_BYPASS_EN. When undefined, an ID read of a
// register being written back in the same cycle stalls one cycle instead.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   rd_sel1/2, rd_use1/2           ID source selects and "actually used" flags
//   wr_en, wr_sel, wr_data         WB write port
//   ex_regwrite, ex_memtoreg, ex_dst  control of instruction held in ID/EX
//   ReadData1/2                    combinational source data
//   stall, bubble                  hold PC/IF-ID, squash ID/EX (identical)
//   stall_count                    saturating stall-cycle count
module id_regfile_hazard
    import id_pkg::*;
#(
    parameter int REG_W = id_pkg::REG_W,
    parameter int NREG  = id_pkg::NREG,
    parameter int SEL_W = id_pkg::SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] rd_sel1,
    input  logic [SEL_W-1:0] rd_sel2,
    input  logic             rd_use1,
    input  logic             rd_use2,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [REG_W-1:0] wr_data,
    input  logic             ex_regwrite,
    input  logic             ex_memtoreg,
    input  logic [SEL_W-1:0] ex_dst,
    output logic [REG_W-1:0] ReadData1,
    output logic [REG_W-1:0] ReadData2,
    output logic             stall,
    output logic             bubble,
    output logic [15:0]      stall_count
);

    logic        ld_haz;
    logic        wb_haz;
    logic [15:0] stall_count_q;
    logic [15:0] stall_count_d;

    rf_core #(
        .REG_W (REG_W),
        .NREG  (NREG),
        .SEL_W (SEL_W)
    ) u_rf_core (
        .clk       (clk),
        .rst       (rst),
        .rd_sel1   (rd_sel1),
        .rd_sel2   (rd_sel2),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2)
    );

    // Only a load in ID/EX forces a stall; ALU results are forwarded later.
    assign ld_haz = ex_regwrite & ex_memtoreg &
                    ((rd_use1 & (ex_dst == rd_sel1)) |
                     (rd_use2 & (ex_dst == rd_sel2)));

`ifdef ID_RF_BYPASS_EN
    assign wb_haz = 1'b0;
`else
    // Without bypass the stored value is stale this cycle; reread next cycle.
    assign wb_haz = wr_en &
                    ((rd_use1 & (wr_sel == rd_sel1)) |
                     (rd_use2 & (wr_sel == rd_sel2)));
`endif

    assign stall  = ld_haz | wb_haz;
    assign bubble = stall;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_id_regfile_hazard.sv
module tb_id_regfile_hazard;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rd_sel1, rd_sel2, wr_sel, ex_dst;
    logic        rd_use1, rd_use2, wr_en, ex_regwrite, ex_memtoreg;
    logic [15:0] wr_data;
    logic [15:0] ReadData1, ReadData2, stall_count;
    logic        stall, bubble;

    always #5 clk = ~clk;

    id_regfile_hazard #(.REG_W(16), .NREG(8), .SEL_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_sel1     (rd_sel1),
        .rd_sel2     (rd_sel2),
        .rd_use1     (rd_use1),
        .rd_use2     (rd_use2),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_data     (wr_data),
        .ex_regwrite (ex_regwrite),
        .ex_memtoreg (ex_memtoreg),
        .ex_dst      (ex_dst),
        .ReadData1   (ReadData1),
        .ReadData2   (ReadData2),
        .stall       (stall),
        .bubble      (bubble),
        .stall_count (stall_count)
    );

    typedef struct {
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic        st;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model: architectural state as plain variables.
    logic [15:0] m_regs [8];
    int          m_cnt;

    function automatic logic [15:0] model_read(input logic [2:0] sel, input logic we,
                                               input logic [2:0] ws, input logic [15:0] wd);
`ifdef ID_RF_BYPASS_EN
        if (we && ws == sel) return wd;
`endif
        return m_regs[sel];
    endfunction

    // Does the ID instruction consume register `dst`?
    function automatic logic reads_reg(input logic [2:0] dst, input logic [2:0] s1, input logic [2:0] s2,
                                       input logic u1, input logic u2);
        return (u1 && s1 == dst) || (u2 && s2 == dst);
    endfunction

    task automatic step(input logic r, input logic [2:0] s1, input logic [2:0] s2,
                        input logic u1, input logic u2, input logic we, input logic [2:0] ws,
                        input logic [15:0] wd, input logic exw, input logic exm, input logic [2:0] exd);
        exp_t e;
        logic st;
        rst = r; rd_sel1 = s1; rd_sel2 = s2; rd_use1 = u1; rd_use2 = u2;
        wr_en = we; wr_sel = ws; wr_data = wd;
        ex_regwrite = exw; ex_memtoreg = exm; ex_dst = exd;
        st = (exw && exm && reads_reg(exd, s1, s2, u1, u2));
`ifndef ID_RF_BYPASS_EN
        st = st || (we && reads_reg(ws, s1, s2, u1, u2));
`endif
        e.rd1 = model_read(s1, we, ws, wd);
        e.rd2 = model_read(s2, we, ws, wd);
        e.st  = st;
        e.cnt = 16'(m_cnt);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
            m_cnt = 0;
        end else begin
            if (we) m_regs[ws] = wd;
            if (st && m_cnt < 65535) m_cnt++;
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Monitor: outputs are always presented; compare once per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ReadData1",   ReadData1,        e.rd1);
                chk("ReadData2",   ReadData2,        e.rd2);
                chk("stall",       {15'd0, stall},   {15'd0, e.st});
                chk("bubble",      {15'd0, bubble},  {15'd0, e.st});
                chk("stall_count", stall_count,      e.cnt);
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_cnt = 0;
        rst = 1'b1; rd_sel1 = '0; rd_sel2 = '0; rd_use1 = 1'b0; rd_use2 = 1'b0;
        wr_en = 1'b0; wr_sel = '0; wr_data = '0;
        ex_regwrite = 1'b0; ex_memtoreg = 1'b0; ex_dst = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state: all registers read zero.
        for (int i = 0; i < 8; i += 2)
            step(0, 3'(i), 3'(i + 1), 1, 1, 0, 0, 0, 0, 0, 0);

        // Write R3 while reading it, then read again.
        step(0, 3, 0, 1, 0, 1, 3, 16'hBEEF, 0, 0, 0);
        step(0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0);

        // Load-use on source 2; then bubble in ID/EX; then rd_use2=0.
        step(0, 0, 5, 0, 1, 0, 0, 0, 1, 1, 5);
        step(0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 5);
        step(0, 0, 5, 0, 0, 0, 0, 0, 1, 1, 5);
        // ALU producer in ID/EX: no stall.
        step(0, 5, 0, 1, 0, 0, 0, 0, 1, 0, 5);

        // Reset with a simultaneous write: write dropped.
        step(0, 2, 2, 0, 0, 1, 2, 16'h5555, 0, 0, 0);
        step(1, 2, 2, 0, 0, 1, 2, 16'h1234, 0, 0, 0);
        step(0, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic, with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 63) == 0), 3'($urandom), 3'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 16'($urandom),
                 1'($urandom), 1'($urandom), 3'($urandom));
        end

        // Saturation: hold a load-use condition well past 65535 cycles.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 70000; n++)
            step(0, 0, 5, 0, 1, 0, 0, 0, 1, 1, 5);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
